// File: rtl/user_pixel_store_pkg.sv
// Shared types and constants for the user-domain pixel store.
// FSM state encoding, CSR offsets, STATUS bit positions, the OBI request and
// response layouts used by the store, and a byte-lane extraction helper.
package user_pixel_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [11:0] STATUS_OFFSET    = 12'h100;
    localparam logic [11:0] REQ_COUNT_OFFSET = 12'h104;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OOB_BIT     = 1;
    localparam int STATUS_CLR_CNT_BIT = 2;

    localparam int OBI_ID_W = 4;

    typedef struct packed {
        logic                req;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [OBI_ID_W-1:0] aid;
    } upx_obi_req_t;

    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        logic [31:0]         rdata;
        logic                err;
        logic [OBI_ID_W-1:0] rid;
    } upx_obi_rsp_t;

    // Pick byte lane 'lane' out of a little-endian 32-bit word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/user_pixel_store_port.sv
// Pixel-fetch responder: IDLE -> WAIT -> RESP -> IDLE.
// Accepts a request in IDLE, latches the byte presented by the array in that
// same cycle, and pulses rom_valid_o exactly ReadLatency cycles later.
module user_pixel_store_port
    import user_pixel_store_pkg::*;
#(
    parameter int unsigned ReadLatency = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rom_req_i,
    input  logic [7:0] rom_byte_i,
    output logic       accept_o,
    output logic       busy_o,
    output logic [7:0] rom_data_o,
    output logic       rom_valid_o
);

    localparam int unsigned CntW = (ReadLatency > 2) ? $clog2(ReadLatency) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(ReadLatency - 1);

    state_e          state_r;
    logic [CntW-1:0] cnt_r;
    logic [7:0]      data_r;
    logic            valid_r;

    // Responder FSM with latency counter, data latch and registered strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CntW'(0);
            data_r  <= 8'h00;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (rom_req_i) begin
                        data_r <= rom_byte_i;
                        cnt_r  <= CntLoad;
                        if (ReadLatency == 1) begin
                            state_r <= ST_RESP;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - CntW'(1);
                    // Counter reaching zero on this edge means RESP starts now.
                    if (cnt_r == CntW'(1)) begin
                        state_r <= ST_RESP;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                        valid_r <= 1'b0;
                    end
                end
                ST_RESP: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Acceptance is only possible in IDLE; RESP never samples the stale address.
    always_comb begin
        accept_o    = (state_r == ST_IDLE) && rom_req_i;
        busy_o      = (state_r != ST_IDLE);
        rom_data_o  = data_r;
        rom_valid_o = valid_r;
    end

endmodule

// File: rtl/user_pixel_store.sv
// User-domain pixel store: software-loadable byte array served to the
// edge-detection accelerator over a fixed-latency rom_req/rom_valid port.
// OBI map (offset = addr[11:0]): 0x000..Depth-1 pixel words, 0x100 STATUS,
// 0x104 REQ_COUNT. Optional build macro USER_PIXEL_STORE_STATS_EN adds the
// 32-bit accepted-request counter; without it 0x104 behaves as unmapped.
module user_pixel_store
    import user_pixel_store_pkg::*;
#(
    parameter type         obi_req_t   = upx_obi_req_t,
    parameter type         obi_rsp_t   = upx_obi_rsp_t,
    parameter int unsigned Depth       = 64,
    parameter int unsigned ReadLatency = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    obi_req_i,
    output obi_rsp_t    obi_rsp_o,
    input  logic        rom_req_i,
    input  logic [31:0] rom_addr_i,
    output logic [7:0]  rom_data_o,
    output logic        rom_valid_o
);

    localparam int unsigned Words = Depth / 4;
    localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

    logic [31:0]     mem_r [Words];

    logic [IdxW-1:0] rom_idx_s;
    logic            rom_oob_s;
    logic [7:0]      rom_byte_s;
    logic            accept_s;
    logic            busy_s;

    logic [11:0]     off_s;
    logic [IdxW-1:0] obi_idx_s;
    logic            pix_hit_s;
    logic            status_hit_s;
    logic            cnt_hit_s;
    logic            pix_wr_s;
    logic            status_wr_s;
    logic            oob_clr_s;
    logic [31:0]     status_s;
    logic [31:0]     count_s;
    logic [31:0]     rd_data_s;
    logic            rd_err_s;

    logic            oob_r;
    logic            rvalid_r;
    logic [31:0]     rdata_r;
    logic            err_r;
    logic [OBI_ID_W-1:0] rid_r;

    logic            unused_s;
    assign unused_s = ^obi_req_i.addr[31:12];

    user_pixel_store_port #(
        .ReadLatency (ReadLatency)
    ) u_port (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rom_req_i   (rom_req_i),
        .rom_byte_i  (rom_byte_s),
        .accept_o    (accept_s),
        .busy_o      (busy_s),
        .rom_data_o  (rom_data_o),
        .rom_valid_o (rom_valid_o)
    );

    // Addressed pixel byte as seen before any same-cycle OBI write; OOB reads as zero.
    always_comb begin
        rom_idx_s = rom_addr_i[IdxW+1:2];
        rom_oob_s = (rom_addr_i >= 32'(Depth));
        if (rom_oob_s) begin
            rom_byte_s = 8'h00;
        end else begin
            rom_byte_s = byte_lane(mem_r[rom_idx_s], rom_addr_i[1:0]);
        end
    end

    // OBI address decode and write strobes.
    always_comb begin
        off_s        = obi_req_i.addr[11:0];
        obi_idx_s    = obi_req_i.addr[IdxW+1:2];
        pix_hit_s    = (off_s < 12'(Depth));
        status_hit_s = (off_s == STATUS_OFFSET);
        cnt_hit_s    = (off_s == REQ_COUNT_OFFSET);
        pix_wr_s     = obi_req_i.req && obi_req_i.we && pix_hit_s;
        status_wr_s  = obi_req_i.req && obi_req_i.we && status_hit_s && obi_req_i.be[0];
        oob_clr_s    = status_wr_s && obi_req_i.wdata[STATUS_OOB_BIT];
        status_s     = {30'h0, oob_r, busy_s};
    end

    // Pixel array: byte-enabled OBI writes, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Words); i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (pix_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (obi_req_i.be[b]) begin
                    mem_r[obi_idx_s][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
                end
            end
        end
    end

    // Sticky out-of-range flag; hardware set beats a same-cycle software clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oob_r <= 1'b0;
        end else if (accept_s && rom_oob_s) begin
            oob_r <= 1'b1;
        end else if (oob_clr_s) begin
            oob_r <= 1'b0;
        end else begin
            oob_r <= oob_r;
        end
    end

`ifdef USER_PIXEL_STORE_STATS_EN
    localparam logic StatsEn = 1'b1;
    logic [31:0] count_r;
    logic        cnt_clr_s;
    assign cnt_clr_s = status_wr_s && obi_req_i.wdata[STATUS_CLR_CNT_BIT];
    assign count_s   = count_r;

    // Accepted-request counter; a software clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= 32'h0;
        end else if (cnt_clr_s) begin
            count_r <= 32'h0;
        end else if (accept_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end
`else
    localparam logic StatsEn = 1'b0;
    assign count_s = 32'h0;
`endif

    // Read data and error for the current OBI request.
    always_comb begin
        rd_data_s = 32'h0;
        rd_err_s  = 1'b0;
        if (obi_req_i.we) begin
            if (pix_hit_s || status_hit_s) begin
                rd_err_s = 1'b0;
            end else begin
                rd_err_s = 1'b1;
            end
        end else begin
            if (pix_hit_s) begin
                rd_data_s = mem_r[obi_idx_s];
            end else if (status_hit_s) begin
                rd_data_s = status_s;
            end else if (cnt_hit_s && StatsEn) begin
                rd_data_s = count_s;
            end else begin
                rd_err_s = 1'b1;
            end
        end
    end

    // OBI response phase: one cycle after the granted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
            err_r    <= 1'b0;
            rid_r    <= '0;
        end else if (obi_req_i.req) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            err_r    <= rd_err_s;
            rid_r    <= obi_req_i.aid;
        end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0;
            err_r    <= 1'b0;
            rid_r    <= rid_r;
        end
    end

    // Grant is combinational; everything else comes from the response registers.
    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_r;
        obi_rsp_o.rdata  = rdata_r;
        obi_rsp_o.err    = err_r;
        obi_rsp_o.rid    = rid_r;
    end

endmodule
